// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed 32-bit memory slave with a configurable number
//               of wait states, byte-enabled writes, abort on request drop
//               and error reporting for simultaneous read/write requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY     = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_ERROR = 2'd3
  } op_t;

  localparam int         c_depth     = 2 ** ADDR_W;
  localparam bit         c_zero_wait = (WAIT_STATES == 0);
  // Counter value loaded on acceptance; a value of zero means the BUSY phase
  // is empty and the access goes straight to COMPLETE (WAIT_STATES == 1).
  localparam logic [3:0] c_load      = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [31:0]       r_mem [c_depth];
  state_t            r_state;
  op_t               r_op;
  logic [ADDR_W-1:0] r_index;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [3:0]        r_cnt;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_index;
  op_t               w_op;
  logic              w_req;
  logic              w_we;
  logic [ADDR_W-1:0] w_we_index;
  logic [31:0]       w_we_data;
  logic [3:0]        w_we_be;
  logic [31:0]       w_merged;
  logic [31:0]       w_unused_addr;

  assign w_index       = addr_i[ADDR_W+1:2];
  assign w_unused_addr = {addr_i[31:ADDR_W+2], addr_i[1:0], {ADDR_W{1'b0}}};

  // Decode the live request; nothing is seen as a request while in reset
  always_comb begin
    w_op = OP_NONE;
    if (rst_i) begin
      if (rd_i && wr_i) begin
        w_op = OP_ERROR;
      end else if (rd_i) begin
        w_op = OP_READ;
      end else if (wr_i) begin
        w_op = OP_WRITE;
      end
    end
    w_req = (w_op != OP_NONE);
  end

  // Select the single write source: a latched write completing, or a
  // zero-wait write accepted directly in IDLE
  always_comb begin
    w_we       = 1'b0;
    w_we_index = r_index;
    w_we_data  = r_wdata;
    w_we_be    = r_be;
    if (rst_i) begin
      if (r_state == S_COMPLETE && r_op == OP_WRITE) begin
        w_we = 1'b1;
      end else if (c_zero_wait && r_state == S_IDLE && w_op == OP_WRITE) begin
        w_we       = 1'b1;
        w_we_index = w_index;
        w_we_data  = wdata_i;
        w_we_be    = be_i;
      end
    end
  end

  // Merge enabled bytes of the write data over the current word
  always_comb begin
    w_merged = r_mem[w_we_index];
    for (int b = 0; b < 4; b++) begin
      if (w_we_be[b]) begin
        w_merged[8*b +: 8] = w_we_data[8*b +: 8];
      end
    end
  end

  // Storage array; deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      r_mem[w_we_index] <= w_merged;
    end
  end

  // Access sequencing: accept, count wait states, complete or abort
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_op    <= OP_NONE;
      r_index <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!c_zero_wait && w_req) begin
            r_op    <= w_op;
            r_index <= w_index;
            r_wdata <= wdata_i;
            r_be    <= be_i;
            if (c_load == 4'd0) begin
              r_state <= S_COMPLETE;
              r_cnt   <= 4'd0;
              r_rdata <= (w_op == OP_READ) ? r_mem[w_index] : 32'd0;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= c_load;
            end
          end
        end
        S_BUSY: begin
          if (!rd_i && !wr_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_COMPLETE;
              r_rdata <= (r_op == OP_READ) ? r_mem[r_index] : 32'd0;
            end
          end
        end
        S_COMPLETE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; zero-wait mode answers combinationally from IDLE
  always_comb begin
    ready_o = 1'b1;
    err_o   = 1'b0;
    rdata_o = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (c_zero_wait) begin
          err_o = (w_op == OP_ERROR);
          if (w_op == OP_READ) begin
            rdata_o = r_mem[w_index];
          end
        end else begin
          ready_o = !w_req;
        end
      end
      S_BUSY: begin
        ready_o = 1'b0;
      end
      S_COMPLETE: begin
        err_o   = (r_op == OP_ERROR);
        rdata_o = r_rdata;
      end
      default: begin
        ready_o = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder; four instances with
//               WAIT_STATES 0..3 checked against a word-array reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_a    [N];
  logic        wr_a    [N];
  logic [31:0] addr_a  [N];
  logic [31:0] wdata_a [N];
  logic [3:0]  be_a    [N];
  logic [31:0] rdata_a [N];
  logic        ready_a [N];
  logic        err_a   [N];

  int vectors     = 0;
  int miscompares = 0;

  // Reference memory per instance, indexed by word address
  bit [31:0] mdl [N][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_W      (10),
      .WAIT_STATES (g)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .rd_i    (rd_a[g]),
      .wr_i    (wr_a[g]),
      .addr_i  (addr_a[g]),
      .wdata_i (wdata_a[g]),
      .be_i    (be_a[g]),
      .rdata_o (rdata_a[g]),
      .ready_o (ready_a[g]),
      .err_o   (err_a[g])
    );
  end

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
    bit [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
    return m;
  endfunction

  // Drive one access held until ready; report latency and completion values
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output logic [31:0] rdat, output logic e, output int lat, output int zero_bad);
    rd_a[k] = r; wr_a[k] = w; addr_a[k] = a; wdata_a[k] = wd; be_a[k] = b;
    lat = -1; rdat = '0; e = 1'b0; zero_bad = 0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (ready_a[k] === 1'b1) begin
        lat = c; rdat = rdata_a[k]; e = err_a[k];
      end else if (rdata_a[k] !== 32'd0 || err_a[k] !== 1'b0) begin
        zero_bad++;
      end
      @(posedge clk); #1;
    end
    rd_a[k] = 1'b0; wr_a[k] = 1'b0;
  endtask

  // Full-word write that also updates the reference
  task automatic prime(input int k, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rdat; logic e; int lat, zb;
    access(k, 1'b0, 1'b1, a, wd, 4'hF, rdat, e, lat, zb);
    mdl[k][a[11:2]] = wd;
    vectors++;
    if (lat !== k) begin
      miscompares++;
      $display("FAIL prime_latency dut%0d: got %0d expected %0d", k, lat, k);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (ready_a[k] !== 1'b1 || err_a[k] !== 1'b0 || rdata_a[k] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got ready=%b err=%b rdata=%h expected 1 0 0",
                 k, ready_a[k], err_a[k], rdata_a[k]);
      end
    end
    rd_a[2] = 1'b1; #1;
    vectors++;
    if (ready_a[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_with_request: got %b expected 1", ready_a[2]);
    end
    rd_a[2] = 1'b0;
  endtask

  task automatic test_write_read_ws2();
    logic [31:0] rdat; logic e; int lat, zb;
    access(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rdat, e, lat, zb);
    mdl[2][4] = 32'hDEADBEEF;
    vectors++;
    if (lat !== 2 || zb !== 0) begin
      miscompares++;
      $display("FAIL ws2_write_latency: got %0d (nonzero-while-busy %0d) expected 2", lat, zb);
    end
    access(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rdat, e, lat, zb);
    vectors++;
    if (lat !== 2 || rdat !== mdl[2][4]) begin
      miscompares++;
      $display("FAIL ws2_read: got lat=%0d data=%h expected lat=2 data=%h", lat, rdat, mdl[2][4]);
    end
  endtask

  task automatic test_zero_wait_be();
    logic [31:0] rdat; logic e; int lat, zb;
    access(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rdat, e, lat, zb);
    mdl[0][8] = 32'h11223344;
    vectors++;
    if (lat !== 0) begin miscompares++; $display("FAIL ws0_write1_ready: got lat %0d expected 0", lat); end
    access(0, 1'b0, 1'b1, 32'h20, 32'h0000AA00, 4'h2, rdat, e, lat, zb);
    mdl[0][8] = merge(mdl[0][8], 32'h0000AA00, 4'h2);
    vectors++;
    if (lat !== 0) begin miscompares++; $display("FAIL ws0_write2_ready: got lat %0d expected 0", lat); end
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rdat, e, lat, zb);
    vectors++;
    if (lat !== 0 || rdat !== mdl[0][8]) begin
      miscompares++;
      $display("FAIL ws0_read_merged: got lat=%0d data=%h expected lat=0 data=%h", lat, rdat, mdl[0][8]);
    end
    access(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rdat, e, lat, zb);
    vectors++;
    if (lat !== 0 || e !== 1'b1 || rdat !== 32'd0) begin
      miscompares++;
      $display("FAIL ws0_error: got lat=%0d err=%b data=%h expected 0 1 0", lat, e, rdat);
    end
  endtask

  task automatic test_error_ws3();
    logic [31:0] rdat; logic e; int lat, zb;
    prime(3, 32'h0, 32'hC0FFEE01);
    access(3, 1'b1, 1'b1, 32'h0, 32'h12345678, 4'hF, rdat, e, lat, zb);
    vectors++;
    if (lat !== 3 || e !== 1'b1 || rdat !== 32'd0) begin
      miscompares++;
      $display("FAIL ws3_error: got lat=%0d err=%b data=%h expected 3 1 0", lat, e, rdat);
    end
    access(3, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rdat, e, lat, zb);
    vectors++;
    if (rdat !== mdl[3][0] || e !== 1'b0) begin
      miscompares++;
      $display("FAIL ws3_error_no_write: got data=%h err=%b expected %h 0", rdat, e, mdl[3][0]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rdat; logic e; int lat, zb; int pulses;
    prime(3, 32'h8, 32'hA5A50F0F);
    rd_a[3] = 1'b0; wr_a[3] = 1'b1; addr_a[3] = 32'h8; wdata_a[3] = 32'h55; be_a[3] = 4'hF;
    pulses = 0;
    @(negedge clk); if (ready_a[3] === 1'b1) pulses++;
    @(posedge clk); #1; wr_a[3] = 1'b0;
    @(negedge clk); if (ready_a[3] === 1'b1) pulses++;
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_ready: got %0d ready cycles expected 0", pulses); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (ready_a[3] !== 1'b1) begin miscompares++; $display("FAIL abort_idle_cycle2: got ready %b expected 1", ready_a[3]); end
    @(posedge clk); #1;
    access(3, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rdat, e, lat, zb);
    vectors++;
    if (lat !== 3 || rdat !== mdl[3][2]) begin
      miscompares++;
      $display("FAIL abort_no_write: got lat=%0d data=%h expected 3 %h", lat, rdat, mdl[3][2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rdat; logic e; int lat, zb;
    prime(2, 32'h30, 32'h01020304);
    rd_a[2] = 1'b0; wr_a[2] = 1'b1; addr_a[2] = 32'h30; wdata_a[2] = 32'hFEEDFACE; be_a[2] = 4'hF;
    @(negedge clk);
    vectors++;
    if (ready_a[2] !== 1'b0) begin miscompares++; $display("FAIL rstmid_cycle0: got ready %b expected 0", ready_a[2]); end
    @(posedge clk); #2;
    rst_n = 1'b0; wr_a[2] = 1'b0;
    #1;
    vectors++;
    if (ready_a[2] !== 1'b1 || err_a[2] !== 1'b0 || rdata_a[2] !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got ready=%b err=%b data=%h expected 1 0 0", ready_a[2], err_a[2], rdata_a[2]);
    end
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rdat, e, lat, zb);
    vectors++;
    if (lat !== 2 || rdat !== mdl[2][12]) begin
      miscompares++;
      $display("FAIL rstmid_no_write: got lat=%0d data=%h expected 2 %h", lat, rdat, mdl[2][12]);
    end
  endtask

  task automatic test_back_to_back();
    int reads;
    prime(1, 32'h40, 32'h600DF00D);
    rd_a[1] = 1'b1; wr_a[1] = 1'b0; addr_a[1] = 32'h40;
    reads = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (ready_a[1] !== ((c % 2) == 1)) begin
        miscompares++;
        $display("FAIL b2b_ready_c%0d: got %b expected %0d", c, ready_a[1], (c % 2));
      end
      if (ready_a[1] === 1'b1) begin
        reads++;
        vectors++;
        if (rdata_a[1] !== mdl[1][16]) begin
          miscompares++;
          $display("FAIL b2b_data_c%0d: got %h expected %h", c, rdata_a[1], mdl[1][16]);
        end
      end
      @(posedge clk); #1;
    end
    rd_a[1] = 1'b0;
    vectors++;
    if (reads !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", reads); end
  endtask

  task automatic test_random();
    logic [31:0] rdat, a, wd; logic e; int lat, zb; logic [3:0] b; int op;
    bit [31:0] exp_d; bit exp_e; int ix;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 6; j++) begin
        a = $urandom(); a[11:2] = 10'(j * 37 + 1);
        prime(k, a, $urandom());
      end
      for (int t = 0; t < 25; t++) begin
        a = $urandom(); ix = $urandom_range(0, 5) * 37 + 1; a[11:2] = 10'(ix);
        wd = $urandom(); b = 4'($urandom_range(0, 15)); op = $urandom_range(0, 5);
        exp_d = 32'd0; exp_e = 1'b0;
        if (op <= 2) begin
          access(k, 1'b1, 1'b0, a, wd, b, rdat, e, lat, zb);
          exp_d = mdl[k][ix];
        end else if (op <= 4) begin
          access(k, 1'b0, 1'b1, a, wd, b, rdat, e, lat, zb);
          mdl[k][ix] = merge(mdl[k][ix], wd, b);
        end else begin
          access(k, 1'b1, 1'b1, a, wd, b, rdat, e, lat, zb);
          exp_e = 1'b1;
        end
        vectors++;
        if (lat !== k || rdat !== exp_d || e !== exp_e || zb !== 0) begin
          miscompares++;
          $display("FAIL random dut%0d op%0d idx%0d: got lat=%0d data=%h err=%b busybad=%0d expected lat=%0d data=%h err=%b",
                   k, op, ix, lat, rdat, e, zb, k, exp_d, exp_e);
        end
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      rd_a[k] = 1'b0; wr_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0; be_a[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_write_read_ws2();
    test_zero_wait_be();
    test_error_ws3();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 10, word-address width; depth 2**ADDR_W 32-bit words.
- WAIT_STATES, 2, cycles from request to ready; legal 0..15.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- rd_i  in  1  read request level; held by requester until ready_o.
- wr_i  in  1  write request level; held by requester until ready_o.
- addr_i  in  32  byte address; bits [ADDR_W+1:2] index the array, other bits ignored.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables; bit n selects wdata_i[8n+7:8n].
- rdata_o  out  32  read data; valid only while ready_o=1 completes a read.
- ready_o  out  1  completion/idle indication; sampled by requester in the same cycle.
- err_o  out  1  protocol error; valid with ready_o.

Function
REQ-003 FSM states SHALL be IDLE, BUSY, COMPLETE; 2-bit state register.
REQ-004 IDLE, no request: ready_o=1, err_o=0, rdata_o=0.
REQ-005 WAIT_STATES=0: a request in IDLE SHALL complete in the same cycle: ready_o=1, rdata_o=array[index] (combinational read), byte-masked write committed at that clock edge, and the FSM remains in IDLE.
REQ-006 WAIT_STATES>0: a request in IDLE SHALL drive ready_o=0 combinationally in that cycle (cycle 0), latch addr/wdata/be/op, load the counter with WAIT_STATES-1, and go to BUSY.
REQ-007 BUSY: ready_o=0; the counter decrements each cycle; at counter=0 go to COMPLETE, so ready_o=1 occurs exactly in cycle WAIT_STATES.
REQ-008 COMPLETE: ready_o=1.
- Read: rdata_o = latched read data, taken from the array on entry to COMPLETE.
- Write: byte-masked commit of latched data at the end of COMPLETE.
- Next state: IDLE unconditionally.
REQ-009 A request still held in the cycle after COMPLETE SHALL be treated as a new request (back-to-back: each access costs WAIT_STATES+1 cycles with WAIT_STATES>0).
REQ-010 rd_i and wr_i both deasserted in BUSY SHALL abort the access: no write, next state IDLE, no ready pulse for the aborted access.
REQ-011 rd_i and wr_i changes during BUSY, other than full deassertion, SHALL be ignored; the latched op and address govern.
REQ-012 rd_i=1 and wr_i=1 simultaneously in IDLE SHALL be an error.
- Array is not accessed.
- err_o=1 with ready_o, following the same latency as a normal access.
- rdata_o=0.
REQ-013 be_i=0 on a write SHALL complete normally with the array unchanged.
REQ-014 rdata_o SHALL be 0 whenever ready_o=0 or the completing access is a write or an error.
REQ-015 A read at the same index as a write committed in the immediately preceding cycle SHALL return the new data.

Reset
REQ-016 rst_i=0 SHALL asynchronously force: state=IDLE, counter=0, latched registers=0, hence ready_o=1, err_o=0, rdata_o=0.
REQ-017 Array contents SHALL NOT be reset.
REQ-018 Reset asserted mid-access SHALL discard that access with no write.
REQ-019 Reset deassertion SHALL take effect at the next rising edge.

Verification
REQ-020 WAIT_STATES=2, write addr 0x10, wdata 0xDEADBEEF, be 0xF, held until ready.
- Required: ready_o=0 in cycles 0-1 and 1 in cycle 2.
- Then a read of 0x10 returns 0xDEADBEEF at its cycle 2.
REQ-021 WAIT_STATES=0, write 0x11223344 to 0x20, then a write with be=0x2 and wdata 0x0000AA00, then a read of 0x20.
- Required: ready_o=1 every cycle; read returns 0x1122AA44.
REQ-022 WAIT_STATES=3, rd_i=wr_i=1 at 0x0.
- Required: ready_o=1 and err_o=1 in cycle 3; rdata_o=0; array[0] unchanged.
REQ-023 WAIT_STATES=3, write 0x55 to 0x8, wr_i dropped in cycle 1.
- Required: no ready pulse; FSM back in IDLE in cycle 2; a later read of 0x8 returns the prior value.
REQ-024 WAIT_STATES=2, rst_i pulsed low in cycle 1 of a write.
- Required: ready_o=1 immediately (asynchronous); write not committed.
REQ-025 WAIT_STATES=1, rd_i held high for 6 cycles.
- Required: ready_o pattern 0,1,0,1,0,1; three reads complete.
